// File: rtl/qos_wrr_scheduler.sv
// Weighted round-robin pop scheduler for four QoS virtual-channel FIFOs.
// At most one eligible VC is popped per cycle. The popped word and its VC tag
// appear on the registered output stream one cycle later.
module qos_wrr_scheduler #(
  parameter int DATA_W   = 12,
  parameter int WEIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                init,
  input  logic [WEIGHT_W-1:0] weight0,
  input  logic [WEIGHT_W-1:0] weight1,
  input  logic [WEIGHT_W-1:0] weight2,
  input  logic [WEIGHT_W-1:0] weight3,
  input  logic [3:0]          vc_empty,
  input  logic [DATA_W-1:0]   vc_data0,
  input  logic [DATA_W-1:0]   vc_data1,
  input  logic [DATA_W-1:0]   vc_data2,
  input  logic [DATA_W-1:0]   vc_data3,
  input  logic                dest_pause,
  output logic [3:0]          pop_vc,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_vc,
  output logic                active_out,
  output logic                idle_out,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3
  } state_t;

  state_t              r_state;
  logic [WEIGHT_W-1:0] r_weight [4];
  logic [1:0]          r_cur;
  logic [WEIGHT_W-1:0] r_cnt;

  logic [3:0]          w_elig;
  logic [DATA_W-1:0]   w_vdata [4];
  logic                w_grant;
  logic [1:0]          w_gvc;
  logic [WEIGHT_W-1:0] w_cbase;
  logic [WEIGHT_W:0]   w_cnt_next;
  logic                w_burst_done;
  logic                w_do_pop;

  assign state      = r_state;
  assign active_out = (r_state == ST_ACTIVE);
  assign idle_out   = (r_state == ST_IDLE);

  // Eligibility per VC and head-word gather for the output mux.
  always_comb begin
    w_vdata[0] = vc_data0;
    w_vdata[1] = vc_data1;
    w_vdata[2] = vc_data2;
    w_vdata[3] = vc_data3;
    for (int i = 0; i < 4; i++) begin
      w_elig[i] = !vc_empty[i] && (r_weight[i] != '0);
    end
  end

  // Grant selection: stay on cur while eligible, else first eligible after cur.
  // Pops are suppressed in any cycle where reset or init will redirect the FSM.
  always_comb begin : sel
    logic [1:0] v_idx;
    v_idx   = r_cur;
    w_grant = 1'b0;
    w_gvc   = r_cur;
    w_cbase = r_cnt;
    if (w_elig[r_cur]) begin
      w_grant = 1'b1;
    end else begin
      for (int k = 1; k < 4; k++) begin
        v_idx = r_cur + 2'(k);
        if (!w_grant && w_elig[v_idx]) begin
          w_grant = 1'b1;
          w_gvc   = v_idx;
          w_cbase = '0;
        end
      end
    end
    w_do_pop     = (r_state == ST_ACTIVE) && !dest_pause && !reset && !init && w_grant;
    w_cnt_next   = {1'b0, w_cbase} + {{WEIGHT_W{1'b0}}, 1'b1};
    w_burst_done = (w_cnt_next == {1'b0, r_weight[w_gvc]});
    pop_vc       = w_do_pop ? (4'd1 << w_gvc) : 4'd0;
  end

  // FSM, weight latch, burst tracking and registered output stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RESET;
      r_cur     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_vc    <= '0;
      for (int i = 0; i < 4; i++) r_weight[i] <= '0;
    end else begin
      out_valid <= w_do_pop;
      if (w_do_pop) begin
        out_data <= w_vdata[w_gvc];
        out_vc   <= w_gvc;
      end
      if (r_state == ST_INIT) begin
        r_weight[0] <= weight0;
        r_weight[1] <= weight1;
        r_weight[2] <= weight2;
        r_weight[3] <= weight3;
      end
      if (r_state == ST_RESET) begin
        if (init) r_state <= ST_INIT;
      end else if (init) begin
        r_state <= ST_INIT;
        r_cur   <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_INIT: r_state <= ST_IDLE;
          ST_IDLE: begin
            if (!dest_pause && (w_elig != 4'd0)) r_state <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (!dest_pause) begin
              if (w_do_pop) begin
                if (w_burst_done) begin
                  r_cur <= w_gvc + 2'd1;
                  r_cnt <= '0;
                end else begin
                  r_cur <= w_gvc;
                  r_cnt <= w_cnt_next[WEIGHT_W-1:0];
                end
              end
              if (w_elig == 4'd0) r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_RESET;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Bench for qos_wrr_scheduler: FIFO model feeding the DUT, cycle-level
// reference scheduler, directed vector table, corner sequences, random run.
module tb_qos_wrr_scheduler;
  localparam int DATA_W   = 12;
  localparam int WEIGHT_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, init, dest_pause;
  logic [WEIGHT_W-1:0] weight0, weight1, weight2, weight3;
  logic [3:0]          vc_empty;
  logic [DATA_W-1:0]   vc_data0, vc_data1, vc_data2, vc_data3;
  logic [3:0]          pop_vc;
  logic                out_valid, active_out, idle_out;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_vc;
  logic [2:0]          state;

  qos_wrr_scheduler #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) dut (
    .clk(clk), .reset(reset), .init(init),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .vc_empty(vc_empty),
    .vc_data0(vc_data0), .vc_data1(vc_data1), .vc_data2(vc_data2), .vc_data3(vc_data3),
    .dest_pause(dest_pause), .pop_vc(pop_vc), .out_valid(out_valid),
    .out_data(out_data), .out_vc(out_vc), .active_out(active_out),
    .idle_out(idle_out), .state(state)
  );

  int total = 0;
  int bad   = 0;

  // FIFO contents seen by the DUT
  logic [DATA_W-1:0] mem [4][64];
  int hd [4];
  int tl [4];
  int wt_in [4];

  // Reference model: 0=RESET 1=INIT 2=IDLE 3=ACTIVE
  int m_st = 0, m_cur = 0, m_cnt = 0;
  int m_w [4];
  int m_ov = 0, m_od = 0, m_ovc = 0;

  typedef struct {
    bit         load;
    bit         pause;
    logic [3:0] exp_pop;
  } vec_t;
  vec_t vt [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int v, input int n);
    for (int i = 0; i < n; i++) begin
      mem[v][tl[v] % 64] = DATA_W'($urandom);
      tl[v]++;
    end
  endtask

  function automatic int pick(input bit [3:0] el);
    if (el[m_cur]) return m_cur;
    for (int k = 1; k < 4; k++) begin
      int j;
      j = (m_cur + k) % 4;
      if (el[j]) return j;
    end
    return -1;
  endfunction

  // One clock cycle: drive FIFO view, check at negedge, advance model at posedge.
  task automatic cyc(input bit en, output logic [3:0] act);
    bit [3:0] el;
    int g, c;
    logic [3:0] ep;
    logic [DATA_W-1:0] gdata;
    for (int i = 0; i < 4; i++) vc_empty[i] = (hd[i] == tl[i]);
    vc_data0 = mem[0][hd[0] % 64];
    vc_data1 = mem[1][hd[1] % 64];
    vc_data2 = mem[2][hd[2] % 64];
    vc_data3 = mem[3][hd[3] % 64];
    weight0 = WEIGHT_W'(wt_in[0]);
    weight1 = WEIGHT_W'(wt_in[1]);
    weight2 = WEIGHT_W'(wt_in[2]);
    weight3 = WEIGHT_W'(wt_in[3]);
    @(negedge clk);
    for (int i = 0; i < 4; i++) el[i] = (hd[i] != tl[i]) && (m_w[i] != 0);
    g = pick(el);
    ep = (m_st == 3 && !dest_pause && !reset && !init && g >= 0) ? 4'(1 << g) : 4'd0;
    gdata = (g >= 0) ? mem[g][hd[g] % 64] : '0;
    act = pop_vc;
    if (en) begin
      chk("pop_vc", pop_vc, ep);
      chk("state", state, m_st);
      chk("idle_out", idle_out, m_st == 2);
      chk("active_out", active_out, m_st == 3);
      chk("out_valid", out_valid, m_ov);
      chk("out_vc", out_vc, m_ovc);
      chk("out_data", out_data, m_od);
    end
    @(posedge clk);
    if (reset) begin
      m_st = 0; m_cur = 0; m_cnt = 0; m_ov = 0; m_od = 0; m_ovc = 0;
      for (int i = 0; i < 4; i++) m_w[i] = 0;
    end else begin
      m_ov = (ep != 0);
      if (ep != 0) begin m_od = gdata; m_ovc = g; end
      if (m_st == 1) for (int i = 0; i < 4; i++) m_w[i] = wt_in[i];
      if (m_st == 0) begin
        if (init) m_st = 1;
      end else if (init) begin
        m_st = 1; m_cur = 0; m_cnt = 0;
      end else if (m_st == 1) begin
        m_st = 2;
      end else if (m_st == 2) begin
        if (!dest_pause && el != 0) m_st = 3;
      end else if (!dest_pause) begin
        if (ep != 0) begin
          c = (g == m_cur) ? m_cnt : 0;
          if (c + 1 == m_w[g]) begin m_cur = (g + 1) % 4; m_cnt = 0; end
          else begin m_cur = g; m_cnt = c + 1; end
        end
        if (el == 0) m_st = 2;
      end
    end
    if (ep != 0) hd[g]++;
    #1;
  endtask

  task automatic do_init(input int w0, input int w1, input int w2, input int w3);
    logic [3:0] a;
    wt_in[0] = w0; wt_in[1] = w1; wt_in[2] = w2; wt_in[3] = w3;
    init = 1'b1;
    cyc(1, a);
    init = 1'b0;
    cyc(1, a);
  endtask

  initial begin
    logic [3:0] a;
    int pops1, pops3;
    reset = 1'b1; init = 1'b0; dest_pause = 1'b0;
    for (int i = 0; i < 4; i++) begin hd[i] = 0; tl[i] = 0; wt_in[i] = 0; m_w[i] = 0; end
    for (int v = 0; v < 4; v++) for (int j = 0; j < 64; j++) mem[v][j] = '0;

    // Reset held for two clocks
    cyc(0, a);
    cyc(1, a);
    chk("rst_pop", a, 0);
    chk("rst_state", state, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);

    // Init with weights 2,1,1,1
    reset = 1'b0;
    wt_in[0] = 2; wt_in[1] = 1; wt_in[2] = 1; wt_in[3] = 1;
    init = 1'b1;
    cyc(1, a);
    chk("init_state", state, 1);
    init = 1'b0;
    cyc(1, a);
    chk("idle_state", state, 2);
    chk("idle_flag", idle_out, 1);

    // WRR order, then same with a 3-cycle pause after the first VC0 pop
    vt.push_back('{1, 0, 4'h0});
    foreach (vt[i]) ;
    begin
      logic [3:0] ord [16];
      ord = '{4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h1, 4'h2,
              4'h4, 4'h8, 4'h2, 4'h4, 4'h8, 4'h2, 4'h4, 4'h8};
      for (int i = 0; i < 16; i++) vt.push_back('{0, 0, ord[i]});
    end
    vt.push_back('{0, 0, 4'h0});
    vt.push_back('{1, 0, 4'h0});
    vt.push_back('{0, 0, 4'h1});
    vt.push_back('{0, 1, 4'h0});
    vt.push_back('{0, 1, 4'h0});
    vt.push_back('{0, 1, 4'h0});
    vt.push_back('{0, 0, 4'h1});
    vt.push_back('{0, 0, 4'h2});
    vt.push_back('{0, 0, 4'h4});
    vt.push_back('{0, 0, 4'h8});
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].load) for (int v = 0; v < 4; v++) push(v, 4);
      dest_pause = vt[i].pause;
      cyc(1, a);
      chk($sformatf("vec%0d_pop", i), a, vt[i].exp_pop);
    end
    dest_pause = 1'b0;
    repeat (20) cyc(1, a);
    chk("drain_idle", idle_out, 1);

    // Single VC2 with weight 1: back-to-back pops then back to IDLE
    push(2, 5);
    cyc(1, a);
    chk("vc2_enter", a, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, a);
      chk($sformatf("vc2_pop%0d", i), a, 4'h4);
    end
    chk("vc2_active", active_out, 1);
    cyc(1, a);
    chk("vc2_back_idle", idle_out, 1);

    // VC1 disabled: never popped; VC3 still served
    do_init(2, 0, 1, 1);
    push(1, 3);
    repeat (4) begin
      cyc(1, a);
      chk("vc1_dis_pop", a, 0);
      chk("vc1_dis_idle", state, 2);
    end
    push(3, 2);
    pops1 = 0; pops3 = 0;
    repeat (6) begin
      cyc(1, a);
      if (a[1]) pops1++;
      if (a[3]) pops3++;
    end
    chk("vc1_never", pops1, 0);
    chk("vc3_pops", pops3, 2);
    hd[1] = tl[1];

    // Reset in the middle of a VC0 burst
    do_init(2, 1, 1, 1);
    push(0, 4);
    cyc(1, a);
    cyc(1, a);
    chk("burst_first", a, 4'h1);
    reset = 1'b1;
    cyc(1, a);
    chk("midrst_pop", a, 0);
    chk("midrst_state", state, 0);
    chk("midrst_ovalid", out_valid, 0);
    reset = 1'b0;
    repeat (3) begin
      cyc(1, a);
      chk("postrst_pop", a, 0);
      chk("postrst_state", state, 0);
    end

    // Random traffic, pause and init pulses
    do_init($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
    for (int n = 0; n < 600; n++) begin
      for (int v = 0; v < 4; v++)
        if ((tl[v] - hd[v]) < 50 && $urandom_range(99) < 35) push(v, 1);
      dest_pause = ($urandom_range(3) == 0);
      init = ($urandom_range(49) == 0);
      if (init) for (int v = 0; v < 4; v++) wt_in[v] = $urandom_range(4);
      cyc(1, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
